operand_fetch: RTL and testbench
================================

OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 No parameters; datapath width fixed at 16, register address width fixed at 3.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 instr_valid  in  1  upstream instruction offered.
REQ-005 instr  in  16  [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2, [5:0] imm6.
REQ-006 instr_ready  out  1  block accepts instr this cycle.
REQ-007 raddr1, raddr2  out  3 each  register-bank read addresses; bank returns data one cycle later.
REQ-008 rdata1, rdata2  in  16 each  registered read data from register bank.
REQ-009 wb_en, wb_addr, wb_data  in  1/3/16  writeback port, shared with register-bank write port.
REQ-010 op_valid  out  1  operand bundle valid to execute stage.
REQ-011 op_ready  in  1  execute stage consumes bundle.
REQ-012 op_opcode, op_rd  out  4/3  decoded opcode and destination.
REQ-013 op_a, op_b  out  16 each  source operands.

Function
REQ-014 FSM states: IDLE, FETCH, ISSUE.
REQ-015 instr_ready = 1 in IDLE, or in ISSUE when op_ready = 1; 0 in FETCH and ISSUE with op_ready = 0.
REQ-016 Accept = instr_valid & instr_ready; on accept, latch opcode, rd, rs1, rs2, imm6 and go to FETCH.
REQ-017 raddr1/raddr2 = instr[8:6]/instr[5:3] combinationally whenever instr_ready = 1, else the latched rs1/rs2.
REQ-018 FETCH lasts exactly one cycle: capture rdata1/rdata2 into op_a/op_b (subject to REQ-021), then go to ISSUE.
REQ-019 When opcode[3] = 1, op_b = imm6 sign-extended to 16 bits; rdata2 is ignored.
REQ-020 ISSUE: op_valid = 1; bundle held stable until op_ready; on handshake go to FETCH if accept occurs in the same cycle, else IDLE.
REQ-021 Latency accept-to-op_valid = 2 cycles; back-to-back throughput = one instruction every 2 cycles.
REQ-022 Bypass: if wb_en = 1 in the accept cycle and wb_addr equals rs1 (rs2), op_a (op_b) takes wb_data captured that cycle instead of stale rdata.
REQ-023 Bypass in FETCH: if wb_en = 1 and wb_addr matches, wb_data overrides rdata for the matching operand.
REQ-024 Hold update: in ISSUE with op_ready = 0, a wb_en matching held rs1/rs2 replaces op_a/op_b with wb_data; immediate op_b is never overwritten.
REQ-025 Both sources matching wb_addr: both operands updated.
REQ-026 instr_valid ignored when instr_ready = 0; no instruction is dropped or duplicated.

Reset
REQ-027 On rst: state = IDLE, op_valid = 0, op_opcode/op_rd/op_a/op_b = 0, latched fields = 0; an in-flight instruction is discarded.
REQ-028 First accept is possible in the first cycle after rst deasserts.

Configuration
REQ-029 Macro OPERAND_FETCH_BYPASS_EN: when defined, REQ-022..REQ-025 are implemented.
REQ-030 When not defined, operands come only from rdata1/rdata2 and held operands never change; a hazard on the accept or FETCH edge instead forces one extra FETCH cycle (latency 3) to re-read the bank.

Verification
REQ-031 Reset mid-ISSUE with op_valid = 1 -> op_valid = 0 next cycle, all outputs 0, instr_ready = 1.
REQ-032 R2 = 16'h1234, R3 = 16'h0005, instr = 16'h1098 (op 1, rd 0, rs1 2, rs2 3) accepted -> op_valid two cycles later, op_a = 16'h1234, op_b = 16'h0005, op_rd = 0.
REQ-033 instr = 16'h8C7F (op 8, imm6 = 6'h3F) -> op_b = 16'hFFFF; imm6 = 6'h1F -> op_b = 16'h001F.
REQ-034 Accept rs1 = 4 while wb_en = 1, wb_addr = 4, wb_data = 16'hBEEF -> op_a = 16'hBEEF (bypass on) / 3-cycle latency with op_a = 16'hBEEF (bypass off).
REQ-035 op_ready held 0 for 5 cycles, wb to rs2 = 16'h00AA in cycle 3 -> op_b = 16'h00AA thereafter, other fields stable, instr_ready = 0 throughout.
REQ-036 instr_valid and op_ready held 1, 4 instructions -> 4 op_valid handshakes at 2-cycle spacing, in order, none lost.

Source files
------------

// File: rtl/operand_fetch_if.sv
// Operand-fetch handshake bundle: upstream instruction, register-bank
// read/write ports and the operand bundle toward execute.
interface operand_fetch_if;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [2:0]  raddr1;
  logic [2:0]  raddr2;
  logic [15:0] rdata1;
  logic [15:0] rdata2;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        op_valid;
  logic        op_ready;
  logic [3:0]  op_opcode;
  logic [2:0]  op_rd;
  logic [15:0] op_a;
  logic [15:0] op_b;

  modport master (
    output instr_valid, instr, rdata1, rdata2,
    output wb_en, wb_addr, wb_data, op_ready,
    input  instr_ready, raddr1, raddr2,
    input  op_valid, op_opcode, op_rd, op_a, op_b
  );

  modport slave (
    input  instr_valid, instr, rdata1, rdata2,
    input  wb_en, wb_addr, wb_data, op_ready,
    output instr_ready, raddr1, raddr2,
    output op_valid, op_opcode, op_rd, op_a, op_b
  );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch: IDLE/FETCH/ISSUE, registered bank read, imm6 sign-extend.
// OPERAND_FETCH_BYPASS_EN enables writeback forwarding; else refetch on hazard.
module operand_fetch (
  input  logic           clk,
  input  logic           rst,
  operand_fetch_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  opc_q;
  logic [2:0]  rd_q, rs1_q, rs2_q;
  logic [5:0]  imm_q;
  logic [15:0] opa_q, opb_q;
  logic        accept, is_imm, refetch;
  logic        hit1, hit2, ahit1, ahit2;
  logic [15:0] imm_sx, opa_f, opb_f;
`ifdef OPERAND_FETCH_BYPASS_EN
  logic        byp_a_q, byp_b_q;
  logic [15:0] byp_d_q;
`else
  logic        haz_q;
`endif

  assign accept = bus.instr_valid & bus.instr_ready;
  assign is_imm = opc_q[3];
  assign imm_sx = {{10{imm_q[5]}}, imm_q};

  assign hit1  = bus.wb_en & (bus.wb_addr == rs1_q);
  assign hit2  = bus.wb_en & (bus.wb_addr == rs2_q) & ~is_imm;
  assign ahit1 = bus.wb_en & (bus.wb_addr == bus.instr[8:6]);
  assign ahit2 = bus.wb_en & (bus.wb_addr == bus.instr[5:3])
               & ~bus.instr[15];

  assign bus.raddr1 = bus.instr_ready ? bus.instr[8:6] : rs1_q;
  assign bus.raddr2 = bus.instr_ready ? bus.instr[5:3] : rs2_q;

  assign bus.op_opcode = opc_q;
  assign bus.op_rd     = rd_q;
  assign bus.op_a      = opa_q;
  assign bus.op_b      = opb_q;

`ifdef OPERAND_FETCH_BYPASS_EN
  // Newest write wins: FETCH-cycle wb, then accept-cycle wb, then bank.
  assign opa_f = hit1    ? bus.wb_data :
                 byp_a_q ? byp_d_q : bus.rdata1;
  assign opb_f = is_imm  ? imm_sx :
                 hit2    ? bus.wb_data :
                 byp_b_q ? byp_d_q : bus.rdata2;
  assign refetch = 1'b0;
`else
  // Bank reads old data on a same-edge write, so stay until it is fresh.
  assign opa_f   = bus.rdata1;
  assign opb_f   = is_imm ? imm_sx : bus.rdata2;
  assign refetch = haz_q | hit1 | hit2;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = accept ? FETCH : IDLE;
      FETCH:   state_d = refetch ? FETCH : ISSUE;
      ISSUE:   if (bus.op_ready) state_d = accept ? FETCH : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    bus.instr_ready = (state_q == IDLE)
                    | ((state_q == ISSUE) & bus.op_ready);
    bus.op_valid    = (state_q == ISSUE);
  end

  // Field latch, operand capture and held-operand update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opc_q   <= '0;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      imm_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
`ifdef OPERAND_FETCH_BYPASS_EN
      byp_a_q <= 1'b0;
      byp_b_q <= 1'b0;
      byp_d_q <= '0;
`else
      haz_q   <= 1'b0;
`endif
    end else begin
      if (accept) begin
        opc_q   <= bus.instr[15:12];
        rd_q    <= bus.instr[11:9];
        rs1_q   <= bus.instr[8:6];
        rs2_q   <= bus.instr[5:3];
        imm_q   <= bus.instr[5:0];
`ifdef OPERAND_FETCH_BYPASS_EN
        byp_a_q <= ahit1;
        byp_b_q <= ahit2;
        byp_d_q <= bus.wb_data;
`else
        haz_q   <= ahit1 | ahit2;
`endif
      end
      if (state_q == FETCH) begin
        opa_q <= opa_f;
        opb_q <= opb_f;
`ifndef OPERAND_FETCH_BYPASS_EN
        haz_q <= hit1 | hit2;
`endif
      end
`ifdef OPERAND_FETCH_BYPASS_EN
      if ((state_q == ISSUE) && !bus.op_ready) begin
        if (hit1) opa_q <= bus.wb_data;
        if (hit2) opb_q <= bus.wb_data;
      end
`endif
    end
  end
endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a register-bank model and
// an in-order scoreboard of expected operand bundles.
module tb_operand_fetch;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  operand_fetch_if ifc ();
  operand_fetch dut (.clk(clk), .rst(rst), .bus(ifc));

  typedef struct {
    logic [3:0]  opc;
    logic [2:0]  rd;
    logic [15:0] a;
    logic [15:0] b;
    int          acc;
    int          lat;
  } exp_t;

`ifdef OPERAND_FETCH_BYPASS_EN
  localparam int          LAT_HAZ = 2;
  localparam logic [15:0] HOLD_B  = 16'h00AA;
`else
  localparam int          LAT_HAZ = 3;
  localparam logic [15:0] HOLD_B  = 16'h6666;
`endif

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  int nhs = 0;
  int cyc = 0;
  logic pv = 1'b0;
  logic [15:0] regs [8];

  // Registered-read bank; reads see the pre-write value on a shared edge
  always @(posedge clk) begin
    ifc.rdata1 <= regs[ifc.raddr1];
    ifc.rdata2 <= regs[ifc.raddr2];
    if (ifc.wb_en) regs[ifc.wb_addr] <= ifc.wb_data;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] opc, input logic [2:0] rd,
                              input logic [15:0] a, input logic [15:0] b,
                              input int lat);
    exp_t e;
    e.opc = opc; e.rd = rd; e.a = a; e.b = b; e.acc = 0; e.lat = lat;
    return e;
  endfunction

  function automatic logic [15:0] init_val(input int i);
    case (i)
      1: return 16'h7777;
      2: return 16'h1234;
      3: return 16'h0005;
      5: return 16'h5555;
      6: return 16'h6666;
      default: return 16'h0000;
    endcase
  endfunction

  // Monitor: latency at op_valid rise, bundle compare at handshake
  always @(negedge clk) begin
    exp_t e;
    if (rst) pv = 1'b0;
    else begin
      if (ifc.op_valid && !pv) begin
        if (sb.size() > 0) chk("latency", cyc - sb[0].acc, sb[0].lat);
        else chk("spurious_valid", 32'(ifc.op_valid), 0);
      end
      if (ifc.op_valid && ifc.op_ready) begin
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("op_opcode", 32'(ifc.op_opcode), 32'(e.opc));
          chk("op_rd", 32'(ifc.op_rd), 32'(e.rd));
          chk("op_a", 32'(ifc.op_a), 32'(e.a));
          chk("op_b", 32'(ifc.op_b), 32'(e.b));
          nhs++;
        end else chk("spurious_hs", 32'(ifc.op_valid), 0);
      end
      pv = ifc.op_valid;
    end
  end

  task automatic offer(input logic sync, input logic [15:0] ins,
                       input exp_t e, input logic wbe,
                       input logic [2:0] wba, input logic [15:0] wbd,
                       output int acc);
    int n;
    if (sync) begin @(posedge clk); #1; end
    ifc.instr_valid = 1'b1;
    ifc.instr = ins;
    ifc.wb_en = wbe;
    ifc.wb_addr = wba;
    ifc.wb_data = wbd;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (ifc.instr_ready) break;
    end
    chk("accept_timeout", 32'(n < 20), 1);
    acc = cyc;
    e.acc = cyc;
    sb.push_back(e);
    @(posedge clk); #1;
    ifc.instr_valid = 1'b0;
    ifc.wb_en = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 40; n++) begin
      @(negedge clk); #1;
      if (sb.size() == 0) break;
    end
    chk("drain", sb.size(), 0);
    @(negedge clk);
  endtask

  task automatic wait_valid();
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (ifc.op_valid) break;
    end
    chk("valid_timeout", 32'(ifc.op_valid), 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_op_valid"}, 32'(ifc.op_valid), 0);
    chk({tag, "_instr_ready"}, 32'(ifc.instr_ready), 1);
    chk({tag, "_op_a"}, 32'(ifc.op_a), 0);
    chk({tag, "_op_b"}, 32'(ifc.op_b), 0);
    chk({tag, "_op_opcode"}, 32'(ifc.op_opcode), 0);
    chk({tag, "_op_rd"}, 32'(ifc.op_rd), 0);
  endtask

  initial begin
    int acc;
    int rel;
    int bb[4];
    ifc.instr_valid = 1'b0;
    ifc.instr = '0;
    ifc.wb_en = 1'b0;
    ifc.wb_addr = '0;
    ifc.wb_data = '0;
    ifc.op_ready = 1'b1;
    rst = 1'b1;

    // Preload bank through the writeback port while held in reset
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      ifc.wb_en = 1'b1;
      ifc.wb_addr = 3'(i);
      ifc.wb_data = init_val(i);
    end
    @(posedge clk); #1;
    ifc.wb_en = 1'b0;
    @(negedge clk);
    chk_reset_outputs("reset");

    // First accept in the first cycle out of reset
    @(posedge clk); #1;
    rst = 1'b0;
    rel = cyc;
    offer(1'b0, 16'h1098, mk(4'h1, 3'd0, 16'h1234, 16'h0005, 2),
          1'b0, 3'd0, 16'h0, acc);
    chk("first_accept", acc, rel);
    drain();

    // Immediate operand sign extension
    offer(1'b1, 16'h8C7F, mk(4'h8, 3'd6, 16'h7777, 16'hFFFF, 2),
          1'b0, 3'd0, 16'h0, acc);
    drain();
    offer(1'b1, 16'h8C5F, mk(4'h8, 3'd6, 16'h7777, 16'h001F, 2),
          1'b0, 3'd0, 16'h0, acc);
    drain();

    // Writeback to rs1 in the accept cycle
    offer(1'b1, 16'h2328, mk(4'h2, 3'd1, 16'hBEEF, 16'h5555, LAT_HAZ),
          1'b1, 3'd4, 16'hBEEF, acc);
    drain();

    // Stalled issue with writeback to held rs2; instr_valid offered
    ifc.op_ready = 1'b0;
    offer(1'b1, 16'h34B0, mk(4'h3, 3'd2, 16'h1234, HOLD_B, 2),
          1'b0, 3'd0, 16'h0, acc);
    wait_valid();
    ifc.instr_valid = 1'b1;
    ifc.instr = 16'h7BA0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk("hold_instr_ready", 32'(ifc.instr_ready), 0);
      chk("hold_op_valid", 32'(ifc.op_valid), 1);
      chk("hold_op_a", 32'(ifc.op_a), 32'h1234);
      chk("hold_op_rd", 32'(ifc.op_rd), 2);
      chk("hold_op_b", 32'(ifc.op_b),
          32'((k >= 3) ? HOLD_B : 16'h6666));
      @(posedge clk); #1;
      ifc.wb_en = (k == 1);
      ifc.wb_addr = 3'd6;
      ifc.wb_data = 16'h00AA;
    end
    ifc.wb_en = 1'b0;
    ifc.op_ready = 1'b1;
    @(negedge clk);
    chk("hs_accept_ready", 32'(ifc.instr_ready), 1);
    begin
      exp_t e;
      e = mk(4'h7, 3'd5, 16'h00AA, 16'hBEEF, 2);
      e.acc = cyc;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    ifc.instr_valid = 1'b0;
    drain();

    // Back-to-back stream with op_ready held high
    offer(1'b1, 16'h1098, mk(4'h1, 3'd0, 16'h1234, 16'h0005, 2),
          1'b0, 3'd0, 16'h0, bb[0]);
    offer(1'b1, 16'h5668, mk(4'h5, 3'd3, 16'h7777, 16'h5555, 2),
          1'b0, 3'd0, 16'h0, bb[1]);
    offer(1'b1, 16'h6F50, mk(4'h6, 3'd7, 16'h5555, 16'h1234, 2),
          1'b0, 3'd0, 16'h0, bb[2]);
    offer(1'b1, 16'hF8E0, mk(4'hF, 3'd4, 16'h0005, 16'hFFE0, 2),
          1'b0, 3'd0, 16'h0, bb[3]);
    for (int i = 1; i < 4; i++) chk("b2b_spacing", bb[i] - bb[i-1], 2);
    drain();

    // Reset while a bundle is being offered
    ifc.op_ready = 1'b0;
    offer(1'b1, 16'h1098, mk(4'h1, 3'd0, 16'h1234, 16'h0005, 2),
          1'b0, 3'd0, 16'h0, acc);
    wait_valid();
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("midreset");
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    ifc.op_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_idle", 32'(ifc.op_valid), 0);

    chk("handshakes", nhs, 10);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
